// File: rtl/tdm_demux_1x4.sv
// rtl/tdm_demux_1x4.sv - 1-to-4 TDM slot demultiplexer with sync-marker framing
module tdm_demux_1x4 #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             sync,
    input  logic             err_clr,
    output logic [3:0]       ch_we,
    output logic [1:0]       slot,
    output logic [4*W-1:0]   dout,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);

    logic [1:0]       slot_q, slot_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             fv_q, fv_d;
    logic [4*W-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     ch_q [4];
    logic [W-1:0]     ch_d [4];

    logic       accept;
    logic       misalign;
    logic [1:0] eff;

    always_comb begin
        accept   = din_valid & (locked_q | sync);
        eff      = sync ? 2'd0 : slot_q;
        misalign = accept & sync & locked_q & (slot_q != 2'd0);
        ch_we    = (rst_n & accept) ? (4'b0001 << eff) : 4'b0000;

        slot_d   = slot_q;
        locked_d = locked_q;
        fv_d     = 1'b0;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            ch_d[i] = ch_q[i];
        end

        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (eff == 2'(i)) ch_d[i] = din;
            end
            slot_d   = eff + 2'd1;
            locked_d = 1'b1;
            // Slot 3 closes the frame; din bypasses ch_q so dout is whole at this edge.
            if (eff == 2'd3) begin
                dout_d = {din, ch_q[2], ch_q[1], ch_q[0]};
                fv_d   = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end

        // A new misalignment outranks a simultaneous clear request.
        if (misalign)     err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q   <= 2'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            fv_q     <= 1'b0;
            dout_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            slot_q   <= slot_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    assign slot        = slot_q;
    assign dout        = dout_q;
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb/tb_tdm_demux_1x4.sv - randomized and directed bench for tdm_demux_1x4 against a frame-assembly model
module tb_tdm_demux_1x4;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             sync;
    logic             err_clr;
    logic [3:0]       ch_we;
    logic [1:0]       slot;
    logic [4*W-1:0]   dout;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
    logic [CNT_W-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    tdm_demux_1x4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .err_clr    (err_clr),
        .ch_we      (ch_we),
        .slot       (slot),
        .dout       (dout),
        .frame_valid(frame_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a frame is a list of samples collected since the last sync or emission.
    logic             m_locked;
    logic             m_fv;
    logic             m_err;
    logic [4*W-1:0]   m_dout;
    logic [CNT_W-1:0] m_cnt;
    logic [W-1:0]     m_part [$];
    logic [3:0]       exp_we;
    logic [3:0]       obs_we;

    task automatic model_reset();
        m_locked = 1'b0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
        m_dout   = '0;
        m_cnt    = '0;
        m_part.delete();
    endtask

    task automatic cyc(input logic [W-1:0] d, input logic v, input logic s, input logic c, input logic r);
        logic acc;
        din       = d;
        din_valid = v;
        sync      = s;
        err_clr   = c;
        rst_n     = r;
        acc       = r && v && (m_locked || s);
        exp_we    = acc ? 4'(1 << (s ? 0 : m_part.size())) : 4'b0000;
        #3;
        obs_we = ch_we;
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else begin
            m_fv = 1'b0;
            if (c) m_err = 1'b0;
            if (acc) begin
                if (s) begin
                    if (m_locked && m_part.size() != 0) m_err = 1'b1;
                    m_part.delete();
                end
                m_part.push_back(d);
                m_locked = 1'b1;
                if (m_part.size() == 4) begin
                    m_dout = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    m_fv   = 1'b1;
                    m_cnt  = m_cnt + CNT_W'(1);
                    m_part.delete();
                end
            end
        end
    endtask

    task automatic test_reset();
        cyc('0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (slot !== 2'd0)      begin failures++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        checks++; if (dout !== '0)        begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++; if (frame_valid !== 0)  begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        checks++; if (locked !== 0)       begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (sync_err !== 0)     begin failures++; $display("FAIL reset_err got=%b exp=0", sync_err); end
        checks++; if (frame_cnt !== '0)   begin failures++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
        for (int i = 0; i < 3; i++) begin
            cyc(4'hA, 1'b1, 1'b0, 1'b0, 1'b1);
            checks++; if (obs_we !== 4'b0000) begin failures++; $display("FAIL drop_we got=%b exp=0000", obs_we); end
            checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL drop_locked got=%b exp=0", locked); end
            checks++; if (frame_valid !== 0)  begin failures++; $display("FAIL drop_fv got=%b exp=0", frame_valid); end
            checks++; if (slot !== 2'd0)      begin failures++; $display("FAIL drop_slot got=%0d exp=0", slot); end
        end
    endtask

    task automatic test_basic();
        logic [3:0] we_tab [4];
        we_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            cyc(W'(i + 1), 1'b1, i == 0, 1'b0, 1'b1);
            checks++; if (obs_we !== we_tab[i]) begin failures++; $display("FAIL basic_we%0d got=%b exp=%b", i, obs_we, we_tab[i]); end
        end
        checks++; if (dout !== 16'h4321)     begin failures++; $display("FAIL basic_dout got=%h exp=4321", dout); end
        checks++; if (frame_valid !== 1'b1)  begin failures++; $display("FAIL basic_fv got=%b exp=1", frame_valid); end
        checks++; if (frame_cnt !== 2'd1)    begin failures++; $display("FAIL basic_cnt got=%0d exp=1", frame_cnt); end
        checks++; if (slot !== 2'd0)         begin failures++; $display("FAIL basic_slot got=%0d exp=0", slot); end
        cyc('0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (frame_valid !== 1'b0)  begin failures++; $display("FAIL basic_fv_pulse got=%b exp=0", frame_valid); end
        checks++; if (dout !== 16'h4321)     begin failures++; $display("FAIL basic_dout_hold got=%h exp=4321", dout); end
    endtask

    task automatic test_stall();
        cyc(4'h1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (slot !== 2'd2)     begin failures++; $display("FAIL stall_slot got=%0d exp=2", slot); end
            checks++; if (obs_we !== 4'b0)   begin failures++; $display("FAIL stall_we got=%b exp=0000", obs_we); end
        end
        cyc(4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(4'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (dout !== 16'h4321)     begin failures++; $display("FAIL stall_dout got=%h exp=4321", dout); end
        checks++; if (frame_valid !== 1'b1)  begin failures++; $display("FAIL stall_fv got=%b exp=1", frame_valid); end
        checks++; if (sync_err !== 1'b0)     begin failures++; $display("FAIL stall_err got=%b exp=0", sync_err); end
        checks++; if (frame_cnt !== 2'd2)    begin failures++; $display("FAIL stall_cnt got=%0d exp=2", frame_cnt); end
    endtask

    task automatic test_misalign();
        logic [W-1:0] vals [6];
        logic         syn  [6];
        vals = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        syn  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cyc(vals[i], 1'b1, syn[i], 1'b0, 1'b1);
            if (i < 5) begin
                checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL mis_fv%0d got=%b exp=0", i, frame_valid); end
            end
            if (i == 2) begin
                checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", sync_err); end
                checks++; if (slot !== 2'd1)     begin failures++; $display("FAIL mis_slot got=%0d exp=1", slot); end
                checks++; if (obs_we !== 4'b0001) begin failures++; $display("FAIL mis_we got=%b exp=0001", obs_we); end
            end
        end
        checks++; if (dout !== 16'hA987)     begin failures++; $display("FAIL mis_dout got=%h exp=a987", dout); end
        checks++; if (frame_valid !== 1'b1)  begin failures++; $display("FAIL mis_fv got=%b exp=1", frame_valid); end
        checks++; if (frame_cnt !== 2'd3)    begin failures++; $display("FAIL mis_cnt got=%0d exp=3", frame_cnt); end
    endtask

    task automatic test_err_clr();
        cyc(4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL clr_prio got=%b exp=1", sync_err); end
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL clr_clear got=%b exp=0", sync_err); end
        cyc(4'h3, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (slot !== 2'd1)     begin failures++; $display("FAIL clr_syncnv_slot got=%0d exp=1", slot); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL clr_syncnv_err got=%b exp=0", sync_err); end
        checks++; if (obs_we !== 4'b0)   begin failures++; $display("FAIL clr_syncnv_we got=%b exp=0000", obs_we); end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] seq [5];
        int n, last, pulses;
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n = 0; last = -1; pulses = 0;
        cyc('0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(W'($urandom), 1'b1, k == 0, 1'b0, 1'b1);
                checks++; if (frame_valid !== (k == 3)) begin failures++; $display("FAIL b2b_fv f%0d k%0d got=%b", f, k, frame_valid); end
                if (frame_valid === 1'b1) begin
                    if (last >= 0) begin
                        checks++; if (n - last != 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", n - last); end
                    end
                    last = n;
                    pulses++;
                    checks++; if (frame_cnt !== seq[f]) begin failures++; $display("FAIL b2b_cnt f%0d got=%0d exp=%0d", f, frame_cnt, seq[f]); end
                    checks++; if (dout !== m_dout)      begin failures++; $display("FAIL b2b_dout f%0d got=%h exp=%h", f, dout, m_dout); end
                end
                n++;
            end
        end
        checks++; if (pulses != 5) begin failures++; $display("FAIL b2b_pulses got=%0d exp=5", pulses); end
        cyc(W'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(W'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
        cyc('0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midrst_locked got=%b exp=0", locked); end
        checks++; if (slot !== 2'd0)   begin failures++; $display("FAIL midrst_slot got=%0d exp=0", slot); end
        checks++; if (obs_we !== 4'b0) begin failures++; $display("FAIL midrst_we got=%b exp=0000", obs_we); end
        for (int i = 0; i < 4; i++) begin
            cyc(W'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
            checks++; if (obs_we !== 4'b0)      begin failures++; $display("FAIL postrst_we got=%b exp=0000", obs_we); end
            checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL postrst_fv got=%b exp=0", frame_valid); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
            checks++; if (obs_we !== exp_we)             begin failures++; $display("FAIL rnd_we i=%0d got=%b exp=%b", i, obs_we, exp_we); end
            checks++; if (slot !== 2'(m_part.size()))    begin failures++; $display("FAIL rnd_slot i=%0d got=%0d exp=%0d", i, slot, m_part.size()); end
            checks++; if (dout !== m_dout)               begin failures++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, dout, m_dout); end
            checks++; if (frame_valid !== m_fv)          begin failures++; $display("FAIL rnd_fv i=%0d got=%b exp=%b", i, frame_valid, m_fv); end
            checks++; if (locked !== m_locked)           begin failures++; $display("FAIL rnd_locked i=%0d got=%b exp=%b", i, locked, m_locked); end
            checks++; if (sync_err !== m_err)            begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, sync_err, m_err); end
            checks++; if (frame_cnt !== m_cnt)           begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, frame_cnt, m_cnt); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
        err_clr   = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_stall();
        test_misalign();
        test_err_clr();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
